mc_datapath_p: RTL and testbench
================================

Name: mc_datapath_p

Overview:
Parametrised next-generation multicycle datapath for the ARM-subset core. It keeps the single-ported-memory, multi-step structure and adds three things:
- Generic data width and register count.
- A global stall for a slow-memory handshake.
- An iterative shift-add multiplier sharing the A/WriteData operand registers.

The block is driven by the multicycle controller FSM. It connects to one unified instruction/data memory through Adr/WriteData/ReadData.

Parameters:
WIDTH, 32, datapath/word width in bits (>= 8, even)
NREG, 16, register-file entries; index NREG-1 is the PC alias
RAW, 4, register address width, clog2(NREG)
PC_INC, 4, increment constant on SrcB input 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears every register in the block
Adr  out  WIDTH  memory address: PC (AdrSrc=0) or Result (AdrSrc=1)
WriteData  out  WIDTH  store data, the RD2 register
ReadData  in  WIDTH  memory read data
Instr  out  WIDTH  instruction register contents
ALUFlags  out  4  {N,Z,C,V} from the current combinational ALU result
Stall  in  1  1 = freeze all datapath registers and the multiplier this cycle
PCWrite, RegWrite, IRWrite  in  1 each  write enables, qualified by !Stall
AdrSrc  in  1  address select
RegSrc  in  2  [0]: RA1 = NREG-1; [1]: RA2 = Instr[15:12]
ALUSrcA  in  1  0 = A, 1 = PC
ALUSrcB  in  2  0 = WriteData, 1 = ExtImm, 2 = PC_INC, 3 = 0
ResultSrc  in  2  0 = ALUOut, 1 = Data, 2 = ALUResult, 3 = MulLo
ImmSrc  in  2  0 = zero-extended imm8, 1 = zero-extended imm12, 2 = sign-extended imm24<<2
ALUControl  in  3  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 PASSB; 6/7 behave as ADD
MulStart  in  1  starts A*WriteData; ignored while MulBusy
MulBusy  out  1  multiplier iterating
MulDone  out  1  one-cycle pulse when the product is valid

Behaviour:
- Reset state: PC, Instr, Data, A, WriteData, ALUOut, all register-file entries, MulLo, MulBusy and MulDone are all 0. Consequently Adr = 0 after reset.
- Combinational reset outputs: ALUFlags reflect the combinational ALU. With the default selects, ADD 0+0 gives Z=1, other flags 0.
- Register updates on the rising clk edge, only when Stall=0:
  - PC <= Result if PCWrite.
  - Instr <= ReadData if IRWrite.
  - Data, A, WriteData and ALUOut load every non-stalled cycle.
  - Register file writes Result to Instr[15:12] if RegWrite.
- Stall=1 holds every register, including multiplier state. Combinational paths remain live.
- Register-file reads are combinational. A read of index NREG-1 returns Result (the PC alias), not the stored entry. A write to NREG-1 is dropped; the PC is updated only through PCWrite.
- ALU: width WIDTH.
  - C = carry out on ADD. On SUB, C = NOT borrow (A >= B unsigned).
  - V = signed overflow on ADD/SUB.
  - C and V are 0 for logic ops.
  - N = msb, Z = all-zero.
- Extend sign- or zero-extends into WIDTH; imm24<<2 truncates to WIDTH when WIDTH < 26.
- Multiplier:
  - States IDLE -> RUN -> DONE -> IDLE.
  - MulStart in IDLE (and !Stall) latches the A and WriteData register values and clears the accumulator.
  - RUN takes exactly WIDTH non-stalled cycles. Each cycle it adds the shifted multiplicand when the multiplier lsb is 1.
  - DONE asserts MulDone for one cycle and updates MulLo (low WIDTH bits, unsigned product) on entry. The FSM then returns to IDLE. MulLo holds until the next completion.
  - MulBusy = 1 in RUN.
  - Total: MulDone appears WIDTH+1 cycles after the MulStart edge, plus one per stalled cycle.
  - MulStart while RUN or DONE is ignored.
  - Reset mid-multiply returns to IDLE with MulLo = 0.
- ALUResult and Result are combinational; there is no extra latency versus the existing datapath.

Decomposition:
- Package mc_pkg holds:
  - ALU op encodings: ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_PASSB.
  - Mux-select constants: RES_ALUOUT, RES_DATA, RES_ALURES, RES_MUL, SRCB_REG, SRCB_IMM, SRCB_INC, SRCB_ZERO.
  - IMM_* encodings.
  - Multiplier state enum mul_state_t.
- One sub-module, mc_mul_iter (parameter WIDTH), containing the FSM and the shift-add multiplier.
- Existing flopr/flopenr/mux2/mux3/regfile-style primitives are instantiated for the remaining registers and muxes.

Test Plan:
- Reset: assert reset mid-cycle, release, no enables -> Adr=0, Instr=0, MulBusy=0, MulLo=0. The reset must take effect without waiting for a clock edge.
- Fetch: ReadData=0xE2811005, IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ALUControl=ADD, ResultSrc=2 -> Instr=0xE2811005, PC=4 after one edge.
- ALU flags: A=0x7FFFFFFF, ALUSrcB=2, ADD -> ALUResult=0x80000003, NZCV=1001. Then A=5, ExtImm=5, SUB -> Z=1, C=1.
- Stall: hold Stall=1 for 3 cycles with PCWrite=1 -> PC unchanged. Deassert Stall -> PC advances on the next edge only.
- Multiply: A=0xFFFF, WriteData=0x10001, pulse MulStart -> MulBusy for 32 cycles, MulDone at cycle 33, MulLo=0xFFFFFFFF. Repeat with 2 stall cycles inserted -> MulDone at cycle 35.
- Corner: R15 read returns Result; RegWrite to Instr[15:12]=15 leaves regfile unchanged. Reset during RUN -> IDLE, MulDone never pulses.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the parametrised multicycle datapath
//
// Purpose : ALU operation codes, mux-select codes, immediate-format codes and
//           the iterative multiplier state type used across mc_datapath_p.
// Ports   : none (package)

package mc_pkg;

    // ALUControl encodings; 6 and 7 fall through to ADD in the ALU.
    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_ORR   = 3'd3;
    localparam logic [2:0] ALU_EOR   = 3'd4;
    localparam logic [2:0] ALU_PASSB = 3'd5;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;
    localparam logic [1:0] RES_MUL    = 2'd3;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_INC  = 2'd2;
    localparam logic [1:0] SRCB_ZERO = 2'd3;

    // ImmSrc encodings
    localparam logic [1:0] IMM_8  = 2'd0;
    localparam logic [1:0] IMM_12 = 2'd1;
    localparam logic [1:0] IMM_24 = 2'd2;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mc_datapath_p_if.sv
// rtl/mc_datapath_p_if.sv - controller/memory bundle for mc_datapath_p
//
// Purpose : groups memory bus, control inputs and status outputs of the
//           datapath.
// Modports: master - controller + memory side (drives controls, ReadData)
//           slave  - datapath side (drives Adr, WriteData, Instr, flags,
//                    multiplier status)

interface mc_datapath_p_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Adr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] ReadData;
    logic [WIDTH-1:0] Instr;
    logic [3:0]       ALUFlags;
    logic             Stall;
    logic             PCWrite;
    logic             RegWrite;
    logic             IRWrite;
    logic             AdrSrc;
    logic [1:0]       RegSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ResultSrc;
    logic [1:0]       ImmSrc;
    logic [2:0]       ALUControl;
    logic             MulStart;
    logic             MulBusy;
    logic             MulDone;

    modport master (
        input  Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone,
        output ReadData, Stall, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, MulStart
    );

    modport slave (
        output Adr, WriteData, Instr, ALUFlags, MulBusy, MulDone,
        input  ReadData, Stall, PCWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, MulStart
    );
endinterface

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled register with asynchronous active-high reset
//
// Ports: clk, reset (async, high), en, d[WIDTH] -> q[WIDTH]

module flopenr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mc_mul_iter.sv
// rtl/mc_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits
//
// Ports: clk, reset (async, high), stall (freeze all state), start,
//        a, b [WIDTH] (operands sampled on start) -> busy, done (1-cycle),
//        lo [WIDTH] (last completed product, holds until next completion)

module mc_mul_iter
    import mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t       state, state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [CW-1:0]    cnt;

    // Only the low WIDTH bits are kept, so the multiplicand may shift out.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       state <= MUL_IDLE;
        else if (!stall) state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: if (start) state_next = MUL_RUN;
            MUL_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = MUL_DONE;
            end
            MUL_DONE: begin
                done       = 1'b1;
                state_next = MUL_IDLE;
            end
            default: state_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            lo     <= '0;
        end else if (!stall) begin
            if (state == MUL_IDLE && start) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL_RUN) begin
                acc    <= acc_step;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                // Publish on the edge that enters DONE.
                if (cnt == LAST) lo <= acc_step;
            end
        end
    end
endmodule

// File: rtl/mux2.sv
// rtl/mux2.sv - two-input word multiplexer
//
// Ports: d0, d1 [WIDTH], s -> y [WIDTH]

module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/mux4.sv
// rtl/mux4.sv - four-input word multiplexer
//
// Ports: d0..d3 [WIDTH], s[2] -> y [WIDTH]

module mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = d0;
        case (s)
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - register file with combinational reads and PC alias
//
// Ports: clk, reset (async, high), we, wa/ra1/ra2 [RAW], wd [WIDTH],
//        alias_val [WIDTH] (value returned for index NREG-1) -> rd1, rd2

module regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16,
    parameter int RAW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RAW-1:0]   wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [RAW-1:0]   ra1,
    input  logic [RAW-1:0]   ra2,
    input  logic [WIDTH-1:0] alias_val,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);
    localparam logic [RAW-1:0] PC_IDX = RAW'(NREG - 1);

    logic [WIDTH-1:0] mem [NREG];

    // The top entry belongs to the PC: writes there are discarded so the PC
    // only ever changes through PCWrite.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && (wa != PC_IDX)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == PC_IDX) ? alias_val : mem[ra1];
    assign rd2 = (ra2 == PC_IDX) ? alias_val : mem[ra2];
endmodule

// File: rtl/mc_datapath_p.sv
// rtl/mc_datapath_p.sv - parametrised multicycle datapath with stall and multiplier
//
// Purpose : PC/IR/Data/A/WriteData/ALUOut registers, register file with PC
//           alias, extender, ALU with NZCV flags, result/address muxes and an
//           iterative multiplier sharing the A/WriteData operand registers.
// Ports   : clk, reset (async, high), bus (mc_datapath_p_if.slave: memory
//           Adr/WriteData/ReadData, Instr, ALUFlags, controls, Stall,
//           MulStart/MulBusy/MulDone)

module mc_datapath_p
    import mc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREG   = 16,
    parameter int RAW    = 4,
    parameter int PC_INC = 4
) (
    input  logic            clk,
    input  logic            reset,
    mc_datapath_p_if.slave  bus
);
    localparam logic [RAW-1:0] PC_IDX = RAW'(NREG - 1);

    logic             run;
    logic [WIDTH-1:0] pc, instr, data, a_q, wd_q, aluout;
    logic [WIDTH-1:0] rd1, rd2, extimm, srca, srcb, aluresult, result, mullo, adr;
    logic [RAW-1:0]   ra1, ra2, wa;
    logic             flag_c, flag_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] srcb_x;
    logic             is_sub;

    // Every datapath register honours the global stall.
    assign run = !bus.Stall;

    flopenr #(.WIDTH(WIDTH)) u_pc    (.clk(clk), .reset(reset), .en(run & bus.PCWrite), .d(result),       .q(pc));
    flopenr #(.WIDTH(WIDTH)) u_instr (.clk(clk), .reset(reset), .en(run & bus.IRWrite), .d(bus.ReadData), .q(instr));
    flopenr #(.WIDTH(WIDTH)) u_data  (.clk(clk), .reset(reset), .en(run),               .d(bus.ReadData), .q(data));
    flopenr #(.WIDTH(WIDTH)) u_a     (.clk(clk), .reset(reset), .en(run),               .d(rd1),          .q(a_q));
    flopenr #(.WIDTH(WIDTH)) u_wd    (.clk(clk), .reset(reset), .en(run),               .d(rd2),          .q(wd_q));
    flopenr #(.WIDTH(WIDTH)) u_alu   (.clk(clk), .reset(reset), .en(run),               .d(aluresult),    .q(aluout));

    assign ra1 = bus.RegSrc[0] ? PC_IDX : instr[16 +: RAW];
    assign ra2 = bus.RegSrc[1] ? instr[12 +: RAW] : instr[0 +: RAW];
    assign wa  = instr[12 +: RAW];

    regfile #(.WIDTH(WIDTH), .NREG(NREG), .RAW(RAW)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .we        (run & bus.RegWrite),
        .wa        (wa),
        .wd        (result),
        .ra1       (ra1),
        .ra2       (ra2),
        .alias_val (result),
        .rd1       (rd1),
        .rd2       (rd2)
    );

    // imm24 is sign-extended then scaled by 4; the oversized concatenation is
    // truncated so narrow datapaths simply drop the upper bits.
    always_comb begin
        extimm = '0;
        case (bus.ImmSrc)
            IMM_8:   extimm = WIDTH'(instr[7:0]);
            IMM_12:  extimm = WIDTH'(instr[11:0]);
            IMM_24:  extimm = WIDTH'({{WIDTH{instr[23]}}, instr[23:0], 2'b00});
            default: extimm = '0;
        endcase
    end

    mux2 #(.WIDTH(WIDTH)) u_srca (.d0(a_q), .d1(pc), .s(bus.ALUSrcA), .y(srca));
    mux4 #(.WIDTH(WIDTH)) u_srcb (.d0(wd_q), .d1(extimm), .d2(WIDTH'(PC_INC)), .d3('0),
                                  .s(bus.ALUSrcB), .y(srcb));

    // SUB is computed as A + ~B + 1 so the carry out is directly NOT borrow.
    always_comb begin
        is_sub    = (bus.ALUControl == ALU_SUB);
        srcb_x    = is_sub ? ~srcb : srcb;
        sum       = {1'b0, srca} + {1'b0, srcb_x} + {{WIDTH{1'b0}}, is_sub};
        aluresult = sum[WIDTH-1:0];
        flag_c    = 1'b0;
        flag_v    = 1'b0;
        case (bus.ALUControl)
            ALU_SUB: begin
                flag_c = sum[WIDTH];
                flag_v = (srca[WIDTH-1] != srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            end
            ALU_AND:   aluresult = srca & srcb;
            ALU_ORR:   aluresult = srca | srcb;
            ALU_EOR:   aluresult = srca ^ srcb;
            ALU_PASSB: aluresult = srcb;
            default: begin
                flag_c = sum[WIDTH];
                flag_v = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            end
        endcase
    end

    mc_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .stall (bus.Stall),
        .start (bus.MulStart),
        .a     (a_q),
        .b     (wd_q),
        .busy  (bus.MulBusy),
        .done  (bus.MulDone),
        .lo    (mullo)
    );

    mux4 #(.WIDTH(WIDTH)) u_res (.d0(aluout), .d1(data), .d2(aluresult), .d3(mullo),
                                 .s(bus.ResultSrc), .y(result));
    mux2 #(.WIDTH(WIDTH)) u_adr (.d0(pc), .d1(result), .s(bus.AdrSrc), .y(adr));

    assign bus.Adr       = adr;
    assign bus.WriteData = wd_q;
    assign bus.Instr     = instr;
    assign bus.ALUFlags  = {aluresult[WIDTH-1], (aluresult == '0), flag_c, flag_v};
endmodule

// File: tb/tb_mc_datapath_p.sv
// tb/tb_mc_datapath_p.sv - self-checking bench for mc_datapath_p

module tb_mc_datapath_p;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk;
    logic reset;
    int   ncomp = 0;
    int   nfail = 0;

    logic [31:0] m_pc;
    logic [31:0] m_rf [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_datapath_p_if #(.WIDTH(W)) bus ();

    mc_datapath_p #(.WIDTH(W), .NREG(16), .RAW(4), .PC_INC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.Stall = 0; bus.PCWrite = 0; bus.RegWrite = 0; bus.IRWrite = 0;
        bus.AdrSrc = 0; bus.RegSrc = 2'd0; bus.ALUSrcA = 0; bus.ALUSrcB = 2'd0;
        bus.ResultSrc = 2'd0; bus.ImmSrc = 2'd0; bus.ALUControl = 3'd0; bus.MulStart = 0;
    endtask

    task automatic model_reset();
        m_pc = '0;
        for (int k = 0; k < 16; k++) m_rf[k] = '0;
    endtask

    task automatic load_instr(input logic [31:0] v);
        bus.ReadData = v;
        bus.IRWrite  = 1;
        tick();
        bus.IRWrite  = 0;
    endtask

    // Route a value through ReadData -> Data -> Result into register r.
    task automatic write_reg(input int r, input logic [31:0] v);
        quiet();
        load_instr({16'h0, 4'(r), 12'h0});
        bus.ReadData = v;
        tick();
        bus.ResultSrc = 2'd1;
        bus.RegWrite  = 1;
        tick();
        quiet();
        if (r != 15) m_rf[r] = v;
    endtask

    task automatic load_ops(input logic [31:0] ins);
        quiet();
        load_instr(ins);
        tick();
    endtask

    // Reference ALU from the arithmetic definitions of each operation.
    task automatic alu_ref(input int op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] y, output logic [3:0] f);
        longint sa, sb, ss;
        longint unsigned us;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 0; v = 0;
        case (op)
            1: begin y = a - b; c = (a >= b); ss = sa - sb; v = (ss > SMAX) || (ss < SMIN); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = b;
            default: begin
                us = longint'({32'h0, a}) + longint'({32'h0, b});
                y  = us[31:0];
                c  = us[32];
                ss = sa + sb;
                v  = (ss > SMAX) || (ss < SMIN);
            end
        endcase
        f = {y[31], (y == 32'h0), c, v};
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int nstall, input bit poke);
        longint unsigned p;
        logic [31:0] exp;
        int done_at;
        write_reg(1, a);
        write_reg(2, b);
        load_ops(32'h0001_0002);
        p   = longint'({32'h0, a}) * longint'({32'h0, b});
        exp = p[31:0];
        bus.MulStart = 1;
        tick();
        bus.MulStart  = 0;
        bus.ResultSrc = 2'd3;
        bus.AdrSrc    = 1;
        done_at = 0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (bus.MulDone) begin
                done_at = cyc;
                break;
            end
            if (cyc == 1) check("mul_busy", 32'(bus.MulBusy), 32'd1);
            bus.Stall    = (cyc >= 10) && (cyc < 10 + nstall);
            bus.MulStart = poke && (cyc == 5);
            tick();
        end
        bus.Stall = 0;
        bus.MulStart = 0;
        #1;
        check("mul_latency", 32'(done_at), 32'(33 + nstall));
        check("mul_busy_at_done", 32'(bus.MulBusy), 32'd0);
        check("mul_lo", bus.Adr, exp);
        tick();
        check("mul_done_pulse", 32'(bus.MulDone), 32'd0);
        check("mul_lo_hold", bus.Adr, exp);
        quiet();
    endtask

    initial begin
        logic [31:0] a, b, v, ins, y, exp;
        logic [3:0]  f;
        int op, isel;
        logic [31:0] corner [4];
        bit seen;
        longint s;

        corner[0] = 32'h0; corner[1] = 32'h7FFF_FFFF;
        corner[2] = 32'h8000_0000; corner[3] = 32'hFFFF_FFFF;

        reset = 1;
        bus.ReadData = '0;
        quiet();
        model_reset();
        #12;
        check("rst_adr", bus.Adr, 32'h0);
        check("rst_instr", bus.Instr, 32'h0);
        check("rst_busy", 32'(bus.MulBusy), 32'd0);
        check("rst_done", 32'(bus.MulDone), 32'd0);
        check("rst_flags", 32'(bus.ALUFlags), 32'h4);
        reset = 0;
        tick();

        // Fetch
        bus.ReadData = 32'hE281_1005;
        bus.IRWrite = 1; bus.PCWrite = 1; bus.AdrSrc = 0;
        bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2; bus.ALUControl = 3'd0; bus.ResultSrc = 2'd2;
        tick();
        m_pc = m_pc + 4;
        check("fetch_instr", bus.Instr, 32'hE281_1005);
        check("fetch_pc", bus.Adr, m_pc);

        // Stall holds PC and Instr
        bus.Stall = 1;
        bus.ReadData = $urandom;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_pc", bus.Adr, m_pc);
            check("stall_instr", bus.Instr, 32'hE281_1005);
        end
        bus.Stall = 0;
        bus.IRWrite = 0;
        tick();
        m_pc = m_pc + 4;
        check("unstall_pc", bus.Adr, m_pc);
        quiet();
        tick();
        check("pc_hold", bus.Adr, m_pc);

        // Directed flag cases
        write_reg(1, 32'h7FFF_FFFF);
        load_ops(32'h0001_0002);
        bus.ALUSrcB = 2'd2; bus.ALUControl = 3'd0; bus.ResultSrc = 2'd2; bus.AdrSrc = 1;
        #1;
        check("ovf_res", bus.Adr, 32'h8000_0003);
        check("ovf_flags", 32'(bus.ALUFlags), 32'h9);
        write_reg(1, 32'd5);
        load_ops(32'h0001_0005);
        bus.ALUSrcB = 2'd1; bus.ImmSrc = 2'd0; bus.ALUControl = 3'd1; bus.ResultSrc = 2'd2; bus.AdrSrc = 1;
        #1;
        check("sub_eq_res", bus.Adr, 32'h0);
        check("sub_eq_flags", 32'(bus.ALUFlags), 32'h6);

        // R15 reads return Result
        quiet();
        load_instr(32'h000F_0000);
        v = $urandom;
        bus.ReadData = v;
        tick();
        bus.ResultSrc = 2'd1;
        tick();
        bus.ResultSrc = 2'd2; bus.ALUSrcA = 0; bus.ALUSrcB = 2'd3; bus.AdrSrc = 1;
        #1;
        check("r15_alias", bus.Adr, v);

        // A write aimed at R15 changes neither the PC nor other entries
        write_reg(3, 32'h1234_5678);
        write_reg(15, 32'hDEAD_BEEF);
        check("r15_write_pc", bus.Adr, m_pc);
        load_ops(32'h0003_0000);
        bus.ALUSrcB = 2'd3; bus.ResultSrc = 2'd2; bus.AdrSrc = 1;
        #1;
        check("rf_intact", bus.Adr, m_rf[3]);

        // Randomized ALU operations on register operands
        for (int it = 0; it < 16; it++) begin
            a  = (it < 4) ? corner[it] : $urandom;
            b  = (it < 4) ? corner[3 - it] : $urandom;
            op = $urandom_range(0, 7);
            write_reg(1, a);
            write_reg(2, b);
            load_ops(32'h0001_0002);
            bus.ALUControl = 3'(op); bus.ResultSrc = 2'd2; bus.AdrSrc = 1;
            #1;
            alu_ref(op, m_rf[1], m_rf[2], y, f);
            check("alu_res", bus.Adr, y);
            check("alu_flags", 32'(bus.ALUFlags), 32'(f));
        end

        // Randomized immediate extension through PASSB
        for (int it = 0; it < 8; it++) begin
            ins  = $urandom;
            isel = $urandom_range(0, 2);
            quiet();
            load_instr(ins);
            bus.ALUSrcB = 2'd1; bus.ImmSrc = 2'(isel); bus.ALUControl = 3'd5;
            bus.ResultSrc = 2'd2; bus.AdrSrc = 1;
            #1;
            if (isel == 0)      exp = ins % 256;
            else if (isel == 1) exp = ins % 4096;
            else begin
                s = longint'({32'h0, ins}) % 16777216;
                if (s >= 8388608) s = s - 16777216;
                s = s * 4;
                exp = s[31:0];
            end
            check("ext_imm", bus.Adr, exp);
        end
        quiet();

        // Multiplier
        run_mul(32'h0000_FFFF, 32'h0001_0001, 0, 0);
        run_mul(32'h0000_FFFF, 32'h0001_0001, 2, 1);
        for (int it = 0; it < 3; it++)
            run_mul($urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of a multiply
        write_reg(1, 32'h0000_0123);
        write_reg(2, 32'h0000_0456);
        load_ops(32'h0001_0002);
        bus.MulStart = 1;
        tick();
        bus.MulStart = 0;
        for (int k = 0; k < 10; k++) tick();
        #2;
        reset = 1;
        model_reset();
        #1;
        bus.ResultSrc = 2'd3; bus.AdrSrc = 1;
        #1;
        check("rst_run_busy", 32'(bus.MulBusy), 32'd0);
        check("rst_run_mullo", bus.Adr, 32'h0);
        check("rst_run_instr", bus.Instr, 32'h0);
        bus.AdrSrc = 0;
        #1;
        check("rst_run_pc", bus.Adr, m_pc);
        reset = 0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.MulDone) seen = 1;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        bus.AdrSrc = 1;
        #1;
        check("rst_mullo_stays", bus.Adr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
